// File: rtl/puf_arbiter.sv
// -----------------------------------------------------------------------------
// puf_arbiter
//
// Shares one PUF core between two requesters (0: PC calibration path,
// 1: on-chip test generator). A request is granted round-robin and its
// challenge is latched. The challenge is held for SETTLE_CYCLES, then the
// trigger is pulsed for TRIG_CYCLES. The core's done flag is then awaited,
// and the captured response is presented with a one-cycle rsp_valid pulse.
//
// Optional feature macro: PUF_ARB_TIMEOUT_EN
//   defined   -> WAIT watchdog; after TIMEOUT_CYCLES WAIT cycles without
//                puf_done the transaction ends with rsp_timeout=1 and a
//                zeroed response.
//   undefined -> WAIT lasts until puf_done; rsp_timeout is tied low.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req0/req1         level requests
//   chal0/chal1       challenge of each requester
//   gnt               one-hot owner of the current transaction, 00 when idle
//   busy              high whenever the FSM is not idle
//   puf_challenge     registered challenge to the PUF core
//   puf_trigger       registered trigger to the PUF core
//   puf_done          level done from the PUF core
//   puf_raw/puf_xor   raw and XOR responses from the PUF core
//   rsp_valid         one-cycle pulse, response fields valid
//   rsp_id            requester index of the response
//   rsp_raw/rsp_xor   captured response, held until the next capture
//   rsp_timeout       response was ended by the watchdog
// -----------------------------------------------------------------------------
module puf_arbiter #(
    parameter int CHALLENGE_WIDTH = 32,
    parameter int RESPONSE_WIDTH  = 6,
    parameter int SETTLE_CYCLES   = 2,
    parameter int TRIG_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES  = 1023
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0,
    input  logic                       req1,
    input  logic [CHALLENGE_WIDTH-1:0] chal0,
    input  logic [CHALLENGE_WIDTH-1:0] chal1,
    output logic [1:0]                 gnt,
    output logic                       busy,
    output logic [CHALLENGE_WIDTH-1:0] puf_challenge,
    output logic                       puf_trigger,
    input  logic                       puf_done,
    input  logic [RESPONSE_WIDTH-1:0]  puf_raw,
    input  logic                       puf_xor,
    output logic                       rsp_valid,
    output logic                       rsp_id,
    output logic [RESPONSE_WIDTH-1:0]  rsp_raw,
    output logic                       rsp_xor,
    output logic                       rsp_timeout
);

    generate
        if ((SETTLE_CYCLES < 1) || (TRIG_CYCLES < 1) || (TIMEOUT_CYCLES < 1)) begin : g_param_check
            $error("puf_arbiter: SETTLE_CYCLES, TRIG_CYCLES and TIMEOUT_CYCLES must be >= 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FIRE,
        ST_WAIT,
        ST_RESP
    } state_t;

    // One phase counter serves both LOAD and FIRE.
    localparam int CNT_MAX = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic                       last_reg;       // index granted most recently
    logic [1:0]                 gnt_reg;
    logic [CHALLENGE_WIDTH-1:0] chal_reg;
    logic                       trig_reg;
    logic                       valid_reg;
    logic                       rsp_id_reg;
    logic [RESPONSE_WIDTH-1:0]  rsp_raw_reg;
    logic                       rsp_xor_reg;

    logic                       grant;
    logic                       win;
    logic                       capture;

`ifdef PUF_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_reg;
    logic            timeout_hit;
    logic            rsp_timeout_reg;
`endif

    // Round-robin winner: a tie goes to the index not granted last.
    always_comb begin
        win = 1'b0;
        if (req0 && req1) begin
            win = ~last_reg;
        end else if (req1) begin
            win = 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        grant      = 1'b0;
        capture    = 1'b0;
`ifdef PUF_ARB_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (req0 || req1) begin
                    grant      = 1'b1;
                    state_next = ST_LOAD;
                    cnt_next   = '0;
                end
            end
            ST_LOAD: begin
                if (cnt_reg == SETTLE_LAST) begin
                    state_next = ST_FIRE;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_FIRE: begin
                if (cnt_reg == TRIG_LAST) begin
                    state_next = ST_WAIT;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            ST_WAIT: begin
                // A done in the final watchdog cycle still wins.
                if (puf_done) begin
                    capture    = 1'b1;
                    state_next = ST_RESP;
                end
`ifdef PUF_ARB_TIMEOUT_EN
                else if (wd_reg == WD_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_RESP;
                end
`endif
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // State and transaction registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            last_reg  <= 1'b1;
            gnt_reg   <= 2'b00;
            chal_reg  <= '0;
            trig_reg  <= 1'b0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            // Outputs decoded from the next state so they line up with it.
            trig_reg  <= (state_next == ST_FIRE);
            valid_reg <= (state_next == ST_RESP);
            if (grant) begin
                gnt_reg  <= win ? 2'b10 : 2'b01;
                last_reg <= win;
                chal_reg <= win ? chal1 : chal0;
            end else if (state_reg == ST_RESP) begin
                gnt_reg <= 2'b00;
            end
        end
    end

    // Response capture; fields hold until the next capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_id_reg  <= 1'b0;
            rsp_raw_reg <= '0;
            rsp_xor_reg <= 1'b0;
`ifdef PUF_ARB_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
`endif
        end else if (capture) begin
            rsp_id_reg  <= gnt_reg[1];
            rsp_raw_reg <= puf_raw;
            rsp_xor_reg <= puf_xor;
`ifdef PUF_ARB_TIMEOUT_EN
            rsp_timeout_reg <= 1'b0;
        end else if (timeout_hit) begin
            rsp_id_reg      <= gnt_reg[1];
            rsp_raw_reg     <= '0;
            rsp_xor_reg     <= 1'b0;
            rsp_timeout_reg <= 1'b1;
`endif
        end
    end

`ifdef PUF_ARB_TIMEOUT_EN
    // Watchdog counts consecutive WAIT cycles; cleared outside WAIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg <= '0;
        end else if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
            wd_reg <= wd_reg + 1'b1;
        end else begin
            wd_reg <= '0;
        end
    end

    assign rsp_timeout = rsp_timeout_reg;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign gnt           = gnt_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign puf_challenge = chal_reg;
    assign puf_trigger   = trig_reg;
    assign rsp_valid     = valid_reg;
    assign rsp_id        = rsp_id_reg;
    assign rsp_raw       = rsp_raw_reg;
    assign rsp_xor       = rsp_xor_reg;

endmodule

// File: tb/tb_puf_arbiter.sv
// -----------------------------------------------------------------------------
// tb_puf_arbiter
//
// Directed self-checking bench for puf_arbiter with default timing
// (SETTLE_CYCLES=2, TRIG_CYCLES=4) and TIMEOUT_CYCLES=16. Inputs are driven
// and outputs sampled 1 time unit after the rising edge. One line is printed
// per completed transaction. Honours PUF_ARB_TIMEOUT_EN for the watchdog
// scenario.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_puf_arbiter;

    localparam int CW = 32;
    localparam int RW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, req1;
    logic [CW-1:0] chal0, chal1;
    logic [1:0]    gnt;
    logic          busy;
    logic [CW-1:0] puf_challenge;
    logic          puf_trigger;
    logic          puf_done;
    logic [RW-1:0] puf_raw;
    logic          puf_xor;
    logic          rsp_valid;
    logic          rsp_id;
    logic [RW-1:0] rsp_raw;
    logic          rsp_xor;
    logic          rsp_timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    puf_arbiter #(
        .CHALLENGE_WIDTH(CW),
        .RESPONSE_WIDTH (RW),
        .SETTLE_CYCLES  (2),
        .TRIG_CYCLES    (4),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req0         (req0),
        .req1         (req1),
        .chal0        (chal0),
        .chal1        (chal1),
        .gnt          (gnt),
        .busy         (busy),
        .puf_challenge(puf_challenge),
        .puf_trigger  (puf_trigger),
        .puf_done     (puf_done),
        .puf_raw      (puf_raw),
        .puf_xor      (puf_xor),
        .rsp_valid    (rsp_valid),
        .rsp_id       (rsp_id),
        .rsp_raw      (rsp_raw),
        .rsp_xor      (rsp_xor),
        .rsp_timeout  (rsp_timeout)
    );

    // One line per completed transaction.
    always @(posedge clk) begin
        if (rsp_valid) begin
            $display("%0t txn: id=%0d raw=%0h xor=%0b timeout=%0b",
                     $time, rsp_id, rsp_raw, rsp_xor, rsp_timeout);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [1:0]    grants[3];
    logic          ids[3];
    int            vt[3];
    logic [CW-1:0] chal_tab[4];
    int            trig_cnt, valid_cnt, ng, nv, first_valid, busy_low;
    logic [1:0]    prev_gnt;
    bit            seen;

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        chal0 = '0; chal1 = '0;
        puf_done = 1'b0; puf_raw = '0; puf_xor = 1'b0;
        chal_tab[0] = 32'h1111_0001;
        chal_tab[1] = 32'h2222_0002;
        chal_tab[2] = 32'h3333_0003;
        chal_tab[3] = 32'h4444_0004;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_gnt",   64'(gnt), 64'h0);
        check("rst_busy",  64'(busy), 64'h0);
        check("rst_trig",  64'(puf_trigger), 64'h0);
        check("rst_valid", 64'(rsp_valid), 64'h0);
        check("rst_id",    64'(rsp_id), 64'h0);
        check("rst_raw",   64'(rsp_raw), 64'h0);
        check("rst_xor",   64'(rsp_xor), 64'h0);
        check("rst_tmo",   64'(rsp_timeout), 64'h0);
        check("rst_chal",  64'(puf_challenge), 64'h0);
        rst = 1'b0;
        tick();

        // ---------------- single transaction, req0 ----------------
        req0 = 1'b1;
        chal0 = 32'hA5A5_0001;
        trig_cnt = 0;
        valid_cnt = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            if (puf_trigger) trig_cnt++;
            if (rsp_valid) valid_cnt++;
            if (i == 1) begin
                check("t1_gnt",  64'(gnt), 64'h1);
                check("t1_busy", 64'(busy), 64'h1);
                check("t1_chal", 64'(puf_challenge), 64'hA5A5_0001);
                req0 = 1'b0;
            end
            if (i == 8) begin
                puf_done = 1'b1;
                puf_raw  = 6'h2B;
                puf_xor  = 1'b1;
            end
            if (i == 9) begin
                check("t1_valid_at_9", 64'(rsp_valid), 64'h1);
                check("t1_id",  64'(rsp_id), 64'h0);
                check("t1_raw", 64'(rsp_raw), 64'h2B);
                check("t1_xor", 64'(rsp_xor), 64'h1);
                check("t1_tmo", 64'(rsp_timeout), 64'h0);
                puf_done = 1'b0;
                puf_raw  = 6'h00;
                puf_xor  = 1'b0;
            end
        end
        check("t1_trig_cycles", 64'(trig_cnt), 64'd4);
        check("t1_valid_count", 64'(valid_cnt), 64'd1);
        check("t1_idle_gnt",    64'(gnt), 64'h0);
        check("t1_idle_busy",   64'(busy), 64'h0);
        check("t1_raw_hold",    64'(rsp_raw), 64'h2B);

        // ---------------- round robin, both requesting ----------------
        do_reset();
        req0 = 1'b1; req1 = 1'b1; puf_done = 1'b1;
        chal0 = 32'h0000_00A0; chal1 = 32'h0000_00B1;
        ng = 0; nv = 0; prev_gnt = 2'b00;
        for (int i = 0; i < 60 && nv < 3; i++) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00 && ng < 3) begin
                grants[ng] = gnt;
                ng++;
            end
            prev_gnt = gnt;
            if (rsp_valid) begin
                ids[nv] = rsp_id;
                nv++;
                if (nv == 3) begin
                    req0 = 1'b0;
                    req1 = 1'b0;
                end
            end
        end
        check("rr_resp_count", 64'(nv), 64'd3);
        check("rr_grant_count", 64'(ng), 64'd3);
        if (ng == 3) begin
            check("rr_gnt0", 64'(grants[0]), 64'h1);
            check("rr_gnt1", 64'(grants[1]), 64'h2);
            check("rr_gnt2", 64'(grants[2]), 64'h1);
        end
        if (nv == 3) begin
            check("rr_id0", 64'(ids[0]), 64'h0);
            check("rr_id1", 64'(ids[1]), 64'h1);
            check("rr_id2", 64'(ids[2]), 64'h0);
        end

        // ---------------- streaming, req1 only ----------------
        do_reset();
        puf_done = 1'b1;
        req1 = 1'b1;
        chal1 = chal_tab[0];
        ng = 0; nv = 0; prev_gnt = 2'b00;
        for (int i = 0; i < 60 && nv < 3; i++) begin
            tick();
            if (gnt != 2'b00 && prev_gnt == 2'b00 && ng < 3) begin
                check("st_gnt", 64'(gnt), 64'h2);
                check("st_chal", 64'(puf_challenge), 64'(chal_tab[ng]));
                ng++;
            end
            prev_gnt = gnt;
            if (rsp_valid) begin
                vt[nv] = i;
                nv++;
                chal1 = chal_tab[nv];
                if (nv == 3) req1 = 1'b0;
            end
        end
        check("st_resp_count", 64'(nv), 64'd3);
        if (nv == 3) begin
            check("st_period0", 64'(vt[1] - vt[0]), 64'd9);
            check("st_period1", 64'(vt[2] - vt[1]), 64'd9);
            check("st_last_id", 64'(rsp_id), 64'h1);
        end

        // ---------------- req0 dropped one cycle after grant ----------------
        tick();
        tick();
        req0 = 1'b1;
        chal0 = 32'h0BAD_F00D;
        tick();
        check("drop_gnt", 64'(gnt), 64'h1);
        tick();
        req0 = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("drop_resp_seen", 64'(seen), 64'h1);
        check("drop_id", 64'(rsp_id), 64'h0);
        tick();
        check("drop_idle_gnt", 64'(gnt), 64'h0);
        check("drop_idle_busy", 64'(busy), 64'h0);

        // ---------------- reset during FIRE ----------------
        do_reset();
        puf_done = 1'b0;
        req0 = 1'b1;
        chal0 = 32'h1234_5678;
        tick();
        req0 = 1'b0;
        tick();
        tick();
        check("abort_trig_before", 64'(puf_trigger), 64'h1);
        rst = 1'b1;
        tick();
        check("abort_trig", 64'(puf_trigger), 64'h0);
        check("abort_gnt",  64'(gnt), 64'h0);
        check("abort_busy", 64'(busy), 64'h0);
        rst = 1'b0;
        puf_done = 1'b1;
        valid_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (rsp_valid) valid_cnt++;
        end
        check("abort_no_valid", 64'(valid_cnt), 64'd0);
        req0 = 1'b1;
        chal0 = 32'hDEAD_BEEF;
        tick();
        check("abort_regrant_gnt", 64'(gnt), 64'h1);
        check("abort_regrant_chal", 64'(puf_challenge), 64'hDEAD_BEEF);
        req0 = 1'b0;
        puf_raw = 6'h15;
        puf_xor = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check("abort_regrant_resp", 64'(seen), 64'h1);
        check("abort_regrant_raw", 64'(rsp_raw), 64'h15);

        // ---------------- WAIT with no done ----------------
        do_reset();
        puf_done = 1'b0;
        puf_raw = 6'h3F;
        puf_xor = 1'b1;
        req0 = 1'b1;
        chal0 = 32'hCAFE_0010;
        first_valid = -1;
        busy_low = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 1) req0 = 1'b0;
            if (rsp_valid && first_valid < 0) begin
                first_valid = i;
                check("wd_tmo", 64'(rsp_timeout), 64'h1);
                check("wd_raw", 64'(rsp_raw), 64'h0);
                check("wd_xor", 64'(rsp_xor), 64'h0);
            end
            if (!busy && i < 24) busy_low++;
        end
`ifdef PUF_ARB_TIMEOUT_EN
        // Grant edge 1, WAIT on edges 7..22, RESP on edge 23.
        check("wd_valid_cycle", 64'(first_valid), 64'(23));
        check("wd_busy_low", 64'(busy_low), 64'd0);
        check("wd_idle_after", 64'(busy), 64'h0);
`else
        check("wd_no_valid", 64'(first_valid), 64'hFFFF_FFFF_FFFF_FFFF);
        check("wd_busy_low", 64'(busy_low), 64'd0);
        check("wd_still_busy", 64'(busy), 64'h1);
`endif
        do_reset();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
